mem_arbiter: RTL

Sequences the single byte-wide external RAM/IO port between the instruction cache read path and the data cache read and byte-write paths. Multi-byte reads are split into consecutive byte accesses and reassembled with optional sign extension. Buffered data-cache writes are accepted one byte per cycle. The block sits between `cache_i`/`cache_d` and the top-level `mem_a`/`mem_din`/`mem_dout`/`mem_wr` pins.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arb_assembler.sv | 48 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and address/length helpers for the
// external byte-port arbiter.
package mem_arbiter_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  // UART/IO space is selected by address bits [17:16] == 2'b11.
  function automatic logic is_io_page(input logic [1:0] page);
    return page == 2'b11;
  endfunction

  function automatic logic [2:0] len_to_n(input logic [2:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_assembler.sv
// Collects read bytes into a word at the byte index given by the arbiter and
// presents the word with optional sign extension for 1- and 2-byte reads.
module mem_arb_assembler
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              start,
  input  logic              load,
  input  logic [1:0]        idx,
  input  logic [BYTE_W-1:0] din,
  input  logic [2:0]        nbytes,
  input  logic              sign,
  output logic [REG_W-1:0]  word
);

  logic [REG_W-1:0] bytes_p1;
  logic [REG_W-1:0] merged;

  function automatic logic [REG_W-1:0] sext(input logic [REG_W-1:0] w,
                                            input logic [2:0]       n,
                                            input logic             s);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    b8  = w[7:0];
    h16 = w[15:0];
    case (n)
      3'd1:    return s ? REG_W'(b8)  : {24'd0, w[7:0]};
      3'd2:    return s ? REG_W'(h16) : {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (start)
      bytes_p1 <= '0;
    else if (load)
      bytes_p1[8*idx +: 8] <= din;
  end

  // The byte arriving this cycle is merged in so the final word is ready at the collect edge.
  always_comb begin
    merged = bytes_p1;
    if (load)
      merged[8*idx +: 8] = din;
    word = sext(merged, nbytes, sign);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide external RAM/IO port between icache reads, dcache
// reads and dcache byte writes. Define MEM_ARB_IO_GUARD_EN to throttle IO writes.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_wait_o,
  output logic              ic_done_o,
  output logic [REG_W-1:0]  ic_data_o,
  input  logic              dc_read_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [2:0]        dc_len_i,
  input  logic              dc_sign_i,
  output logic              dc_wait_o,
  output logic              dc_done_o,
  output logic [REG_W-1:0]  dc_data_o,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_w_addr_i,
  input  logic [BYTE_W-1:0] dc_w_data_i,
  output logic              dc_w_wait_o,
  output logic              dc_writing_o,
  input  logic [BYTE_W-1:0] mem_din,
  input  logic              io_buffer_full,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nxt;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] base;
  logic              sign_q;
  logic              owner_dc;
  logic              last_dc;
  logic              busy;
  logic              io_block;
  logic              write_taken;
  logic              ic_wins;
  logic              dc_wins;
  logic              ic_go;
  logic              dc_go;
  logic              asm_start;
  logic              asm_load;
  logic [1:0]        asm_idx;
  logic [REG_W-1:0]  asm_word;

`ifdef MEM_ARB_IO_GUARD_EN
  logic io_wr_last;

  always_ff @(posedge clk) begin
    if (rst)
      io_wr_last <= 1'b0;
    else
      io_wr_last <= write_taken && is_io_page(dc_w_addr_i[17:16]);
  end

  assign io_block = is_io_page(dc_w_addr_i[17:16]) && (io_buffer_full || io_wr_last);
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign io_block       = 1'b0;
`endif

  assign busy         = (state != ST_IDLE);
  assign dc_w_wait_o  = busy | io_block;
  assign write_taken  = dc_write_i && !dc_w_wait_o;
  assign dc_writing_o = write_taken;

  // last_dc set means the dcache had the previous grant, so the icache gets this one.
  assign ic_wins   = ic_read_i && (!dc_read_i || last_dc);
  assign dc_wins   = dc_read_i && (!ic_read_i || !last_dc);
  assign ic_wait_o = busy | write_taken | dc_wins;
  assign dc_wait_o = busy | write_taken | ic_wins;
  assign ic_go     = ic_read_i && !ic_wait_o;
  assign dc_go     = dc_read_i && !dc_wait_o;

  assign cnt_nxt   = cnt + 3'd1;
  assign asm_start = !busy && (ic_go || dc_go);
  assign asm_load  = busy && (cnt != 3'd0);
  assign asm_idx   = cnt[1:0] - 2'd1;

  mem_arb_assembler u_asm (
    .clk    (clk),
    .start  (asm_start),
    .load   (asm_load),
    .idx    (asm_idx),
    .din    (mem_din),
    .nbytes (nbytes),
    .sign   (sign_q),
    .word   (asm_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_dc   <= 1'b0;
      ic_done_o <= 1'b0;
      dc_done_o <= 1'b0;
      ic_data_o <= '0;
      dc_data_o <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
    end else begin
      ic_done_o <= 1'b0;
      dc_done_o <= 1'b0;
      mem_wr    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (write_taken) begin
            mem_a    <= dc_w_addr_i;
            mem_dout <= dc_w_data_i;
            mem_wr   <= 1'b1;
          end else if (ic_go || dc_go) begin
            state    <= ST_RD;
            owner_dc <= dc_go;
            last_dc  <= dc_go;
            base     <= dc_go ? dc_addr_i : ic_addr_i;
            mem_a    <= dc_go ? dc_addr_i : ic_addr_i;
            nbytes   <= dc_go ? len_to_n(dc_len_i) : 3'd4;
            sign_q   <= dc_go && dc_sign_i;
          end
        end
        ST_RD: begin
          cnt <= cnt_nxt;
          if (cnt_nxt < nbytes)
            mem_a <= base + {29'd0, cnt_nxt};
          // Collect cycle: last byte is on mem_din, word completes at this edge.
          if (cnt == nbytes) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (owner_dc) begin
              dc_done_o <= 1'b1;
              dc_data_o <= asm_word;
            end else begin
              ic_done_o <= 1'b1;
              ic_data_o <= asm_word;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
